at_fetch_pc: RTL and testbench
==============================

Name: at_fetch_pc

Overview:
- Fetch-stage PC generator for the always-taken pipelined RV32I core.
- Sits directly upstream of instruction memory and the IF/ID register.
- Holds the architectural fetch PC and a direct-mapped branch target buffer (BTB).
- Predicts every BTB-hit control instruction as taken and redirects fetch to the stored target. Applies EX-stage misprediction redirects and BTB allocations.

Parameters:
- ENTRIES, 16, BTB entry count; power of two, 2..256.
- RESET_PC, 32'h0000_0000, fetch PC after reset; word aligned.

Ports:
- i_clk  in  1  core clock; all state updates on its rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_stall  in  1  hold fetch PC (load-use or structural hazard).
- i_redirect  in  1  EX-stage redirect request (mispredict or jalr).
- i_redirect_pc  in  32  redirect target.
- i_upd_en  in  1  EX has resolved a branch or jal; allocate it in the BTB.
- i_upd_pc  in  32  PC of the resolved instruction.
- i_upd_target  in  32  computed taken-target of that instruction.
- o_pc  out  32  current fetch PC; drives the imem address and o_pc_debug path.
- o_pred_taken  out  1  current PC hits the BTB; forwarded down the pipe.
- o_pred_target  out  32  BTB target for the current PC; 0 when no hit.
- o_hit_cnt  out  32  count of predicted-taken fetches (saturating).
- o_redir_cnt  out  32  count of accepted redirects (saturating).

Behaviour:
- Address split:
  - IDX = log2(ENTRIES).
  - index = pc[IDX+1:2]; tag = pc[31:IDX+2].
  - Each entry holds valid, tag and a 30-bit target (bits [31:2]). Target bits [1:0] are read back as 00.
- Reset (async, i_rstn=0):
  - o_pc = RESET_PC.
  - All valid bits = 0.
  - o_hit_cnt = 0; o_redir_cnt = 0.
  - o_pred_taken = 0; o_pred_target = 0.
  - Tag and target arrays need no reset.
  - A reset asserted mid-stream discards all history; the first fetch after release is RESET_PC.
- Lookup (combinational from o_pc, zero cycles):
  - o_pred_taken = valid[index] & (tag[index] == tag(o_pc)).
  - o_pred_target = o_pred_taken ? target[index] : 0.
- Next PC, priority high to low:
  1. i_redirect -> {i_redirect_pc[31:2], 2'b00}. Redirect beats stall, because the stalled instruction is being flushed.
  2. i_stall -> o_pc held.
  3. o_pred_taken -> o_pred_target.
  4. Otherwise o_pc + 4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
- BTB update:
  - On a rising edge with i_upd_en=1, write entry index(i_upd_pc): valid=1, tag=tag(i_upd_pc), target=i_upd_target[31:2].
  - The write overwrites any aliasing entry; there is no replacement policy.
  - Updates apply regardless of i_stall and i_redirect.
  - Entries are never invalidated except by reset.
  - EX never asserts i_upd_en for jalr.
- Same-cycle update and lookup to the same index:
  - The lookup sees the old contents; there is no write-through bypass.
  - The new entry is visible from the next cycle.
- Counters:
  - o_hit_cnt increments on edges where o_pred_taken=1, i_stall=0 and i_redirect=0.
  - o_redir_cnt increments on edges where i_redirect=1.
  - Both saturate at 32'hFFFF_FFFF.
- Latency:
  - A redirect asserted in cycle n gives o_pc = target in cycle n+1.
  - An allocation in cycle n can hit in cycle n+1.

Test Plan:
- Reset, then no stall, no redirect, empty BTB, for 4 cycles -> o_pc = 0, 4, 8, C; o_pred_taken = 0 throughout; o_hit_cnt = 0.
- Upd at pc=0x10 with target 0x40, then refetch 0x10 via redirect -> at o_pc=0x10: o_pred_taken=1, o_pred_target=0x40; next o_pc=0x40; o_hit_cnt=1; o_redir_cnt=1.
- Aliasing with ENTRIES=16: upd 0x10→0x40, then 0x50→0x80 (same index 4, different tag); redirect to 0x10 -> o_pred_taken=0 at 0x10, next o_pc=0x14; redirect to 0x50 -> hit, next o_pc=0x80.
- i_stall=1 and i_redirect=1 (pc 0x3) together while o_pc=0x8 -> next o_pc=0x0 (aligned redirect wins); with i_stall=1 alone for 3 cycles -> o_pc stays 0x8 and o_hit_cnt does not change.
- Same-cycle upd at 0x20 (target 0x100) while o_pc=0x20 -> that cycle o_pred_taken=0, next o_pc=0x24; after a redirect back to 0x20 -> o_pred_taken=1, next o_pc=0x100.
- Reset asserted mid-run with valid entries and counters at 5 -> immediately o_pc=RESET_PC and counters 0; after release, the previously hitting PC misses.

Source files
------------

// File: rtl/at_fetch_pc.sv
// Purpose: fetch PC register with a direct-mapped BTB that predicts every hit as taken.
// Latency: lookup is combinational from o_pc; redirects and BTB writes take effect next cycle.
// Backpressure: i_stall holds the PC, but a redirect overrides the stall; BTB updates are never blocked.
module at_fetch_pc #(
  parameter int          ENTRIES  = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_upd_en,
  input  logic [31:0] i_upd_pc,
  input  logic [31:0] i_upd_target,
  output logic [31:0] o_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  output logic [31:0] o_hit_cnt,
  output logic [31:0] o_redir_cnt
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = 30 - IDX;

  // BTB storage: only the valid bits are reset; tag/target are qualified by valid.
  logic [ENTRIES-1:0] valid;
  logic [TW-1:0]      tag_mem [ENTRIES];
  logic [29:0]        tgt_mem [ENTRIES];

  logic [IDX-1:0] lk_idx;
  logic [TW-1:0]  lk_tag;
  logic [IDX-1:0] up_idx;
  logic [TW-1:0]  up_tag;
  logic [31:0]    pc_next;
  logic           hit_inc;

  // Byte-offset bits of targets are always forced to zero, so they are dropped here.
  logic unused_low_bits;
  assign unused_low_bits = ^{i_redirect_pc[1:0], i_upd_target[1:0]};

  assign lk_idx = o_pc[IDX+1:2];
  assign lk_tag = o_pc[31:IDX+2];
  assign up_idx = i_upd_pc[IDX+1:2];
  assign up_tag = i_upd_pc[31:IDX+2];

  // Lookup sees the pre-edge array contents, so a same-cycle write is not forwarded.
  always_comb begin
    o_pred_taken  = 1'b0;
    o_pred_target = 32'h0000_0000;
    if (valid[lk_idx] && (tag_mem[lk_idx] == lk_tag)) begin
      o_pred_taken  = 1'b1;
      o_pred_target = {tgt_mem[lk_idx], 2'b00};
    end
  end

  // Next-PC select: a redirect flushes the stalled instruction, so it outranks the stall.
  always_comb begin
    pc_next = o_pc + 32'd4;
    if (i_redirect) begin
      pc_next = {i_redirect_pc[31:2], 2'b00};
    end else if (i_stall) begin
      pc_next = o_pc;
    end else if (o_pred_taken) begin
      pc_next = o_pred_target;
    end
  end

  assign hit_inc = o_pred_taken & ~i_stall & ~i_redirect;

  // Fetch PC and saturating event counters.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_pc        <= RESET_PC;
      o_hit_cnt   <= 32'h0000_0000;
      o_redir_cnt <= 32'h0000_0000;
    end else begin
      o_pc <= pc_next;
      if (hit_inc && (o_hit_cnt != 32'hFFFF_FFFF)) begin
        o_hit_cnt <= o_hit_cnt + 32'd1;
      end
      if (i_redirect && (o_redir_cnt != 32'hFFFF_FFFF)) begin
        o_redir_cnt <= o_redir_cnt + 32'd1;
      end
    end
  end

  // Valid bits: set on allocation, cleared only by reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid <= '0;
    end else if (i_upd_en) begin
      valid[up_idx] <= 1'b1;
    end
  end

  // Tag/target payload: last writer wins on aliasing, no replacement policy.
  always_ff @(posedge i_clk) begin
    if (i_upd_en) begin
      tag_mem[up_idx] <= up_tag;
      tgt_mem[up_idx] <= i_upd_target[31:2];
    end
  end

endmodule

// File: tb/tb_at_fetch_pc.sv
// Bench for at_fetch_pc: directed scenarios plus randomized traffic against a behavioural model.
// Model keeps the BTB as plain arrays indexed with division/modulo arithmetic.
// Every comparison goes through check_eq; the summary line reports the totals.
module tb_at_fetch_pc;

  localparam int          ENTRIES  = 16;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        i_upd_en = 1'b0;
  logic [31:0] i_upd_pc = '0;
  logic [31:0] i_upd_target = '0;
  logic [31:0] o_pc;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic [31:0] o_hit_cnt;
  logic [31:0] o_redir_cnt;

  at_fetch_pc #(.ENTRIES(ENTRIES), .RESET_PC(RESET_PC)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_stall(i_stall), .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc), .i_upd_en(i_upd_en), .i_upd_pc(i_upd_pc),
    .i_upd_target(i_upd_target), .o_pc(o_pc), .o_pred_taken(o_pred_taken),
    .o_pred_target(o_pred_target), .o_hit_cnt(o_hit_cnt), .o_redir_cnt(o_redir_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  logic [31:0] m_pc, m_hit, m_redir;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int m_index(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit m_hits(input logic [31:0] pc);
    int k;
    k = m_index(pc);
    return m_valid[k] && (m_tag[k] == m_tagof(pc));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
    m_pc = RESET_PC; m_hit = 0; m_redir = 0;
  endtask

  // Assert reset asynchronously, check outputs at once, release away from the clock edge.
  task automatic do_reset();
    i_rstn = 1'b0;
    model_reset();
    #1;
    check_eq("rst_pc", o_pc, RESET_PC);
    check_eq("rst_pred", {31'b0, o_pred_taken}, 32'd0);
    check_eq("rst_tgt", o_pred_target, 32'd0);
    check_eq("rst_hit_cnt", o_hit_cnt, 32'd0);
    check_eq("rst_redir_cnt", o_redir_cnt, 32'd0);
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
  endtask

  // One clock: drive inputs, compare outputs with the model, then advance the model.
  task automatic cycle(input bit stall, input bit redir, input logic [31:0] rpc,
                       input bit upd, input logic [31:0] upc, input logic [31:0] utgt);
    bit hit;
    logic [31:0] ptgt;
    int k;
    i_stall = stall; i_redirect = redir; i_redirect_pc = rpc;
    i_upd_en = upd; i_upd_pc = upc; i_upd_target = utgt;
    #1;
    hit  = m_hits(m_pc);
    ptgt = hit ? m_tgt[m_index(m_pc)] : 32'd0;
    check_eq("pc", o_pc, m_pc);
    check_eq("pred_taken", {31'b0, o_pred_taken}, {31'b0, hit});
    check_eq("pred_target", o_pred_target, ptgt);
    check_eq("hit_cnt", o_hit_cnt, m_hit);
    check_eq("redir_cnt", o_redir_cnt, m_redir);
    if (hit && !stall && !redir && m_hit != 32'hFFFF_FFFF) m_hit = m_hit + 1;
    if (redir && m_redir != 32'hFFFF_FFFF) m_redir = m_redir + 1;
    if (redir)      m_pc = rpc & 32'hFFFF_FFFC;
    else if (stall) m_pc = m_pc;
    else if (hit)   m_pc = ptgt;
    else            m_pc = m_pc + 32'd4;
    if (upd) begin
      k = m_index(upc);
      m_valid[k] = 1'b1;
      m_tag[k]   = m_tagof(upc);
      m_tgt[k]   = utgt & 32'hFFFF_FFFC;
    end
    @(posedge i_clk); #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    cycle(0, 1, pc, 0, 0, 0);
  endtask

  logic [31:0] saved_hit;

  initial begin
    model_reset();
    @(posedge i_clk); #1;
    do_reset();

    // Sequential fetch from an empty BTB
    for (int i = 0; i < 4; i++) begin
      check_eq("seq_pc", o_pc, 32'(4 * i));
      idle();
    end
    check_eq("seq_hit_cnt", o_hit_cnt, 32'd0);

    // Allocate 0x10->0x40 while redirecting to 0x10; hit visible next cycle
    cycle(0, 1, 32'h10, 1, 32'h10, 32'h40);
    check_eq("alloc_pred", {31'b0, o_pred_taken}, 32'd1);
    check_eq("alloc_tgt", o_pred_target, 32'h40);
    idle();
    check_eq("alloc_next_pc", o_pc, 32'h40);
    check_eq("alloc_hit_cnt", o_hit_cnt, 32'd1);
    check_eq("alloc_redir_cnt", o_redir_cnt, 32'd1);

    // Aliasing: 0x50 evicts 0x10 at index 4
    cycle(0, 0, 0, 1, 32'h50, 32'h80);
    redirect_to(32'h10);
    check_eq("alias_miss", {31'b0, o_pred_taken}, 32'd0);
    idle();
    check_eq("alias_next", o_pc, 32'h14);
    redirect_to(32'h50);
    check_eq("alias_hit", {31'b0, o_pred_taken}, 32'd1);
    idle();
    check_eq("alias_tgt_pc", o_pc, 32'h80);

    // Redirect beats stall, and its target is word-aligned
    redirect_to(32'h8);
    cycle(1, 1, 32'h3, 0, 0, 0);
    check_eq("redir_over_stall", o_pc, 32'h0);
    redirect_to(32'h8);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0);
    check_eq("stall_hold", o_pc, 32'h8);
    // Stall on a hitting PC must not count hits
    redirect_to(32'h50);
    saved_hit = o_hit_cnt;
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0);
    check_eq("stall_hit_pc", o_pc, 32'h50);
    check_eq("stall_hit_cnt", o_hit_cnt, saved_hit);

    // Same-cycle update and lookup: no bypass
    redirect_to(32'h20);
    check_eq("same_pre", {31'b0, o_pred_taken}, 32'd0);
    cycle(0, 0, 0, 1, 32'h20, 32'h100);
    check_eq("same_next", o_pc, 32'h24);
    redirect_to(32'h20);
    check_eq("same_hit", {31'b0, o_pred_taken}, 32'd1);
    idle();
    check_eq("same_tgt_pc", o_pc, 32'h100);

    // PC wraps at the top of the address space
    redirect_to(32'hFFFF_FFFC);
    idle();
    check_eq("wrap_pc", o_pc, 32'h0);

    // Mid-run reset wipes BTB and counters
    do_reset();
    redirect_to(32'h50);
    check_eq("post_rst_miss", {31'b0, o_pred_taken}, 32'd0);
    idle();
    check_eq("post_rst_next", o_pc, 32'h54);

    // Randomized traffic over a small address window so hits and aliases are frequent
    for (int i = 0; i < 600; i++) begin
      bit st, rd, up;
      logic [31:0] rpc, upc, utg;
      st  = ($urandom_range(0, 99) < 20);
      rd  = ($urandom_range(0, 99) < 15);
      up  = ($urandom_range(0, 99) < 35);
      rpc = 32'($urandom_range(0, 255));
      upc = 32'($urandom_range(0, 255)) & 32'hFFFF_FFFC;
      utg = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle(st, rd, rpc, up, upc, utg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
